ldc_sequencer: RTL
==================

LDC_SEQUENCER -- requirements
Module: ldc_sequencer

Interface
REQ-001 Parameter DEPTH, 4, input FIFO depth in (x,v) pairs (power of two, 2..16).
REQ-002 Parameter TIMEOUT, 1023, maximum cycles spent in WAIT before aborting.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers a sample pair.
REQ-006 in_ready  output  1  sequencer accepts the pair this cycle.
REQ-007 in_x / in_v  input  16 each  position and velocity operands.
REQ-008 ldc_start  output  1  start pulse to the LDC engine.
REQ-009 ldc_x / ldc_v  output  16 each  operands to the engine, registered.
REQ-010 ldc_done  input  1  engine done level.
REQ-011 ldc_distance  input  16  engine result.
REQ-012 out_valid  output  1  result available downstream.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_distance  output  16  result value.
REQ-015 out_err  output  1  result is a timeout abort, not an engine value.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 Input FIFO SHALL accept a pair on the cycle in_valid & in_ready; in_ready = not full, combinational from FIFO count only.
REQ-018 When the FIFO is full, in_ready SHALL be 0, even if a pop occurs the same cycle; no pair is lost or overwritten.
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and HOLD.
REQ-020 IDLE -> ISSUE when the FIFO is non-empty; on that edge the head pair is popped into ldc_x/ldc_v.
REQ-021 IDLE with the FIFO empty SHALL stay in IDLE; no pop on empty.
REQ-022 ldc_start SHALL be 1 exactly while in ISSUE, which lasts one cycle; ISSUE -> WAIT unconditionally.
REQ-023 ldc_x/ldc_v SHALL hold stable from ISSUE until the next pop.
REQ-024 A completion event is ldc_done = 1 in a cycle where its registered previous-cycle value was 0 (rising edge); a done level held high from a previous job is not a completion.
REQ-025 The done-edge register SHALL be updated every cycle in every state.
REQ-026 WAIT + completion: capture ldc_distance into out_distance, out_err = 0, go to HOLD.
REQ-027 WAIT SHALL count cycles from 0; when the count equals TIMEOUT with no completion: out_distance = 16'hFFFF, out_err = 1, go to HOLD.
REQ-028 If a completion and the timeout coincide, the completion SHALL win.
REQ-029 out_valid SHALL be 1 exactly while in HOLD; out_distance/out_err stay stable in HOLD.
REQ-030 HOLD & out_ready: go to ISSUE with a pop if the FIFO is non-empty, else go to IDLE.
REQ-031 HOLD & !out_ready SHALL stay in HOLD indefinitely (backpressure); FIFO pushes continue to be accepted while not full.
REQ-032 ldc_done edges seen outside WAIT SHALL be ignored.
REQ-033 A push and a pop in the same cycle SHALL leave the count unchanged; pointers wrap modulo DEPTH.
REQ-034 Minimum latency, push at edge t into an empty FIFO in IDLE:
  - IDLE -> ISSUE at edge t+1
  - ldc_start high in cycle t+1..t+2

Reset
REQ-035 rst = 0 SHALL immediately force:
  - state IDLE, FIFO empty, WAIT counter 0, done-edge register 0
  - ldc_start 0, out_valid 0, out_err 0, busy 0
  - out_distance 0, ldc_x 0, ldc_v 0
REQ-036 Reset mid-operation (any state) SHALL discard queued pairs and any in-flight job; the first start after release is for the first pair pushed after release.
REQ-037 in_ready SHALL be 1 the first cycle after release.

Verification
REQ-038 Single job: push (x=100, v=3); engine model raises done 20 cycles after start with 16'h0136 -> one ldc_start pulse, ldc_x=100, ldc_v=3; out_valid with out_distance=16'h0136, out_err=0.
REQ-039 Fill/backpressure: out_ready=0, push 6 pairs back-to-back with DEPTH=4 -> in_ready drops after FIFO full; no pair lost; results emerge in push order once out_ready=1.
REQ-040 Timeout: engine never raises done -> after TIMEOUT cycles in WAIT, out_distance=16'hFFFF, out_err=1; the next job proceeds normally.
REQ-041 Sticky done: engine holds done=1 between jobs -> no premature capture; each result is captured only on a fresh rising edge.
REQ-042 Coincidence: done edge on the TIMEOUT cycle -> engine value captured with out_err=0.
REQ-043 Reset mid-WAIT with 3 pairs queued -> outputs at reset values immediately; no ldc_start until a new push; stale pairs never issued.

Source files
------------

// File: rtl/ldc_sequencer_if.sv
// ldc_sequencer_if
//   Groups the three handshakes around the LDC sequencer:
//     upstream sample pairs : in_valid / in_ready / in_x / in_v
//     engine side           : ldc_start / ldc_x / ldc_v / ldc_done / ldc_distance
//     downstream result     : out_valid / out_ready / out_distance / out_err
//     status                : busy
//   Modport "slave" is the sequencer's own view; "master" is the surrounding
//   environment (upstream source, engine and downstream sink together).
interface ldc_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_v;
  logic        ldc_start;
  logic [15:0] ldc_x;
  logic [15:0] ldc_v;
  logic        ldc_done;
  logic [15:0] ldc_distance;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_distance;
  logic        out_err;
  logic        busy;

  modport slave (
    input  in_valid, in_x, in_v, ldc_done, ldc_distance, out_ready,
    output in_ready, ldc_start, ldc_x, ldc_v, out_valid, out_distance, out_err, busy
  );

  modport master (
    output in_valid, in_x, in_v, ldc_done, ldc_distance, out_ready,
    input  in_ready, ldc_start, ldc_x, ldc_v, out_valid, out_distance, out_err, busy
  );
endinterface

// File: rtl/ldc_sequencer.sv
// ldc_sequencer
//   Buffers (x,v) operand pairs in a small FIFO and feeds them one at a time
//   to an LDC engine: a one-cycle start pulse with registered operands, a wait
//   for the engine's done rising edge (or a timeout abort), then a held result
//   presented downstream with valid/ready backpressure.
// Ports
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : ldc_sequencer_if.slave (input FIFO, engine and result handshakes)
// Parameters
//   DEPTH   : FIFO depth in pairs, power of two, 2..16
//   TIMEOUT : last WAIT count value before aborting (>= 1)
module ldc_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input logic            clk,
  input logic            rst,
  ldc_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_full, fifo_empty;
  logic          done_p1, done_rise;
  logic [TW-1:0] wait_cnt;
  logic          timeout_hit, cap_done, cap_timeout;
  logic [15:0]   ldc_x_r, ldc_v_r, out_distance_r;
  logic          out_err_r;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never opens the input early.
  assign fifo_full   = (count == CW'(DEPTH));
  assign fifo_empty  = (count == '0);
  assign push        = bus.in_valid & ~fifo_full;
  assign done_rise   = bus.ldc_done & ~done_p1;
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT));

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A completion on the timeout cycle still counts as a real result.
        if (done_rise) begin
          state_nxt = HOLD;
          cap_done  = 1'b1;
        end else if (timeout_hit) begin
          state_nxt   = HOLD;
          cap_timeout = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (!fifo_empty) begin
            state_nxt = ISSUE;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, FIFO control, done-edge tracking and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      done_p1        <= 1'b0;
      wait_cnt       <= '0;
      ldc_x_r        <= '0;
      ldc_v_r        <= '0;
      out_distance_r <= '0;
      out_err_r      <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_p1 <= bus.ldc_done;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr             <= rd_ptr + AW'(1);
        {ldc_x_r, ldc_v_r} <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (state == WAIT && state_nxt == WAIT) wait_cnt <= wait_cnt + TW'(1);
      else                                    wait_cnt <= '0;
      if (cap_done) begin
        out_distance_r <= bus.ldc_distance;
        out_err_r      <= 1'b0;
      end else if (cap_timeout) begin
        out_distance_r <= 16'hFFFF;
        out_err_r      <= 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_x, bus.in_v};
  end

  assign bus.in_ready     = ~fifo_full;
  assign bus.ldc_start    = (state == ISSUE);
  assign bus.ldc_x        = ldc_x_r;
  assign bus.ldc_v        = ldc_v_r;
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_distance = out_distance_r;
  assign bus.out_err      = out_err_r;
  assign bus.busy         = (state != IDLE);
endmodule
